// File: rtl/adder16_pkg.sv
// Shared constants and types for the adder16 pipeline stage.
package adder16_pkg;

  localparam int ADDER_W = 16;

  typedef struct packed {
    logic s;
    logic zr;
    logic cy;
    logic p;
    logic v;
  } flags_t;

endpackage

// File: rtl/adder16_adder4.sv
// Structural ripple-carry building blocks: a full adder and a 4-bit slice of four of them.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module adder4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [4:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    fulladder u_fa (
      .a    (a_i[i]),
      .b    (b_i[i]),
      .cin  (carry[i]),
      .sum  (s_o[i]),
      .cout (carry[i+1])
    );
  end

  assign c_o = carry[4];

endmodule

// File: rtl/adder16.sv
// 16-bit registered adder stage: structural ripple chain of four adder4 slices plus ALU status flags.
module adder16
  import adder16_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [ADDER_W-1:0] x,
  input  logic [ADDER_W-1:0] y,
  output logic               out_valid,
  output logic [ADDER_W-1:0] z,
  output logic               S,
  output logic               ZR,
  output logic               CY,
  output logic               P,
  output logic               V
);

  localparam int NSLICE = ADDER_W / 4;

  logic [NSLICE:0]    slice_c;
  logic [ADDER_W-1:0] sum_d;
  flags_t             flags_d;

  logic [ADDER_W-1:0] z_q;
  flags_t             flags_q;
  logic               out_valid_q;

  assign slice_c[0] = 1'b0;

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    adder4 u_add4 (
      .a_i (x[4*k +: 4]),
      .b_i (y[4*k +: 4]),
      .c_i (slice_c[k]),
      .s_o (sum_d[4*k +: 4]),
      .c_o (slice_c[k+1])
    );
  end

  // Signed overflow: operands agree in sign but the sum does not.
  always_comb begin
    flags_d.s  = sum_d[ADDER_W-1];
    flags_d.zr = ~|sum_d;
    flags_d.cy = slice_c[NSLICE];
    flags_d.p  = ~^sum_d;
    flags_d.v  = (x[ADDER_W-1] & y[ADDER_W-1] & ~sum_d[ADDER_W-1]) |
                 (~x[ADDER_W-1] & ~y[ADDER_W-1] & sum_d[ADDER_W-1]);
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q         <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        z_q     <= sum_d;
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign S         = flags_q.s;
  assign ZR        = flags_q.zr;
  assign CY        = flags_q.cy;
  assign P         = flags_q.p;
  assign V         = flags_q.v;

endmodule

// File: tb/tb_adder16.sv
// Directed-vector bench for adder16 with hand-computed sums and flags.
module tb_adder16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] x;
  logic [15:0] y;
  logic        out_valid;
  logic [15:0] z;
  logic        S, ZR, CY, P, V;

  int n_tests = 0;
  int n_fail  = 0;

  adder16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .z         (z),
    .S         (S),
    .ZR        (ZR),
    .CY        (CY),
    .P         (P),
    .V         (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [15:0] ez,
                           input logic es, input logic ezr, input logic ecy,
                           input logic ep, input logic eov);
    check({tag, ".valid"}, {15'd0, out_valid}, {15'd0, ev});
    check({tag, ".z"},     z,                  ez);
    check({tag, ".S"},     {15'd0, S},         {15'd0, es});
    check({tag, ".ZR"},    {15'd0, ZR},        {15'd0, ezr});
    check({tag, ".CY"},    {15'd0, CY},        {15'd0, ecy});
    check({tag, ".P"},     {15'd0, P},         {15'd0, ep});
    check({tag, ".V"},     {15'd0, V},         {15'd0, eov});
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic apply(input logic v, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_valid = v;
    x        = a;
    y        = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    x        = '0;
    y        = '0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 16'h0000, 0, 0, 0, 0, 0);

    @(negedge clk);
    rst_n = 1'b1;

    //                      valid  z        S  ZR CY P  V
    apply(1'b1, 16'h8AFF, 16'h0002);
    check_out("8AFF+0002", 1'b1, 16'h8B01, 1, 0, 0, 0, 0);

    // Mid-run reset clears outputs immediately, without a clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 16'h0000, 0, 0, 0, 0, 0);

    // An edge seen while reset is held must not capture anything.
    in_valid = 1'b1;
    x        = 16'h1234;
    y        = 16'h1111;
    @(posedge clk);
    #1;
    check_out("rst_held", 1'b0, 16'h0000, 0, 0, 0, 0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 16'h8FFF, 16'h8000);
    check_out("8FFF+8000", 1'b1, 16'h0FFF, 0, 0, 1, 1, 1);

    apply(1'b1, 16'hFFFE, 16'hA000);
    check_out("FFFE+A000", 1'b1, 16'h9FFE, 1, 0, 1, 0, 0);

    apply(1'b1, 16'hAAAA, 16'h5555);
    check_out("AAAA+5555", 1'b1, 16'hFFFF, 1, 0, 0, 1, 0);

    apply(1'b1, 16'hFFFF, 16'h0001);
    check_out("FFFF+0001", 1'b1, 16'h0000, 0, 1, 1, 1, 0);

    // Back-to-back pairs on consecutive cycles.
    apply(1'b1, 16'h8FFF, 16'h7700);
    check_out("8FFF+7700", 1'b1, 16'h06FF, 0, 0, 1, 1, 0);
    apply(1'b1, 16'h8000, 16'h8000);
    check_out("8000+8000", 1'b1, 16'h0000, 0, 1, 1, 1, 1);

    apply(1'b1, 16'h7FFF, 16'h0001);
    check_out("7FFF+0001", 1'b1, 16'h8000, 1, 0, 0, 0, 1);

    // Idle cycles with changing operands must leave results untouched.
    apply(1'b0, 16'h0001, 16'h0001);
    check_out("hold1", 1'b0, 16'h8000, 1, 0, 0, 0, 1);
    apply(1'b0, 16'hFFFF, 16'hFFFF);
    check_out("hold2", 1'b0, 16'h8000, 1, 0, 0, 0, 1);

    apply(1'b1, 16'h0123, 16'h0456);
    check_out("0123+0456", 1'b1, 16'h0579, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
